multicycle_cu: RTL and testbench

MULTICYCLE_CU -- requirements
Module: multicycle_cu

---
 rtl/cu_pkg.sv | 68 ++++++
 rtl/cu_decoder.sv | 73 +++++++
 rtl/multicycle_cu.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_cu.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Optional macro CU_TRAP_EN adds the TRAP state.
package cu_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
`ifdef CU_TRAP_EN
      , ST_TRAP = 3'd5
`endif
   } state_t;

   typedef enum logic [3:0] {
      CLS_ILLEGAL,
      CLS_R,
      CLS_I,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JAL,
      CLS_JALR,
      CLS_LUI,
      CLS_AUIPC
   } inst_class_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD    = 4'b0000;
   localparam logic [3:0] ALU_BRANCH = 4'b1000;
   localparam logic [3:0] ALU_PASS_B = 4'b1111;

   localparam logic [1:0] PC_PLUS4  = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JALR   = 2'b10;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;

   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_SRX = 3'b101;

   // Byte-enable pattern for a store; halfwords align on addr_lo[1] only.
   function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] addr_lo);
      logic [3:0] m;
      case (f3)
         F3_SB:   m = 4'b0001 << addr_lo;
         F3_SH:   m = 4'b0011 << {addr_lo[1], 1'b0};
         F3_SW:   m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational decode of the latched instruction into class, ALU op and
// operand selects.
module cu_decoder
   import cu_pkg::*;
#(
   parameter int unsigned ALUOP_W = 4
) (
   input  logic [6:0]         opcode,
   input  logic [2:0]         funct3,
   input  logic               funct7_5,
   output inst_class_t        inst_class,
   output logic [ALUOP_W-1:0] aluop,
   output logic               op_a_sel,
   output logic               op_b_sel
);

   // Opcode classification and per-class ALU/operand selection
   always_comb begin
      inst_class = CLS_ILLEGAL;
      aluop      = '0;
      op_a_sel   = 1'b0;
      op_b_sel   = 1'b0;
      case (opcode)
         OP_R: begin
            inst_class = CLS_R;
            aluop      = ALUOP_W'({funct7_5, funct3});
         end
         OP_I: begin
            inst_class = CLS_I;
            aluop      = ALUOP_W'({(funct3 == F3_SRX) ? funct7_5 : 1'b0, funct3});
            op_b_sel   = 1'b1;
         end
         OP_LOAD: begin
            inst_class = CLS_LOAD;
            aluop      = ALUOP_W'(ALU_ADD);
            op_b_sel   = 1'b1;
         end
         OP_STORE: begin
            inst_class = CLS_STORE;
            aluop      = ALUOP_W'(ALU_ADD);
            op_b_sel   = 1'b1;
         end
         OP_BRANCH: begin
            inst_class = CLS_BRANCH;
            aluop      = ALUOP_W'(ALU_BRANCH);
         end
         OP_JAL: begin
            inst_class = CLS_JAL;
            aluop      = ALUOP_W'(ALU_ADD);
            op_a_sel   = 1'b1;
            op_b_sel   = 1'b1;
         end
         OP_JALR: begin
            inst_class = CLS_JALR;
            aluop      = ALUOP_W'(ALU_ADD);
            op_b_sel   = 1'b1;
         end
         OP_LUI: begin
            inst_class = CLS_LUI;
            aluop      = ALUOP_W'(ALU_PASS_B);
            op_b_sel   = 1'b1;
         end
         OP_AUIPC: begin
            inst_class = CLS_AUIPC;
            aluop      = ALUOP_W'(ALU_ADD);
            op_a_sel   = 1'b1;
            op_b_sel   = 1'b1;
         end
         default: inst_class = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multicycle_cu.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a data
// memory timeout. Define CU_TRAP_EN to add a sticky TRAP state for illegal
// opcodes and misaligned halfword stores.
module multicycle_cu
   import cu_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned ALUOP_W     = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        inst,
   input  logic               inst_valid,
   input  logic               mem_ready,
   input  logic               branch_taken,
   input  logic [1:0]         addr_lo,
   output logic [4:0]         rs1,
   output logic [4:0]         rs2,
   output logic [4:0]         rd,
   output logic               ir_we,
   output logic               pc_we,
   output logic               reg_write,
   output logic               mem_req,
   output logic               mem_we,
   output logic [1:0]         pc_sel,
   output logic [1:0]         wb_sel,
   output logic               op_a_sel,
   output logic               op_b_sel,
   output logic [ALUOP_W-1:0] aluop,
   output logic [3:0]         wmask,
   output logic [2:0]         state_o,
   output logic               busy,
   output logic               mem_err,
   output logic               illegal_inst
);

   localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

   state_t             state, next_state;
   logic [31:0]        ir;
   logic [CNT_W-1:0]   tmo_cnt;
   logic               tmo_done;
   logic               trap_set;
   inst_class_t        dec_class;
   logic [ALUOP_W-1:0] dec_aluop;
   logic               dec_op_a, dec_op_b;
   logic               unused_ir_bits;

   assign unused_ir_bits = ^{ir[31], ir[29:25]};

   cu_decoder #(.ALUOP_W(ALUOP_W)) u_dec (
      .opcode     (ir[6:0]),
      .funct3     (ir[14:12]),
      .funct7_5   (ir[30]),
      .inst_class (dec_class),
      .aluop      (dec_aluop),
      .op_a_sel   (dec_op_a),
      .op_b_sel   (dec_op_b)
   );

   assign rs1      = ir[19:15];
   assign rs2      = ir[24:20];
   assign rd       = ir[11:7];
   assign state_o  = state;
   assign busy     = (state != ST_FETCH);
   assign tmo_done = (tmo_cnt == CNT_W'(MEM_TIMEOUT));

   // Decode-derived datapath controls are only presented once an instruction is latched
   assign aluop    = (state == ST_FETCH) ? '0   : dec_aluop;
   assign op_a_sel = (state == ST_FETCH) ? 1'b0 : dec_op_a;
   assign op_b_sel = (state == ST_FETCH) ? 1'b0 : dec_op_b;

   // State register, instruction latch and MEM wait counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_FETCH;
         ir      <= '0;
         tmo_cnt <= '0;
      end else begin
         state <= next_state;
         if (ir_we) begin
            ir <= inst;
         end
         // Held at zero outside MEM so every MEM visit starts a fresh count
         if (state != ST_MEM) begin
            tmo_cnt <= '0;
         end else if (!mem_ready && !tmo_done) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
      end
   end

`ifdef CU_TRAP_EN
   logic illegal_q;

   // Sticky trap flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_q <= 1'b0;
      end else if (trap_set) begin
         illegal_q <= 1'b1;
      end
   end

   assign illegal_inst = illegal_q;
`else
   assign illegal_inst = 1'b0;
`endif

   // Next-state and strobe generation; reset forces every strobe low
   always_comb begin
      next_state = state;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      reg_write  = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      pc_sel     = PC_PLUS4;
      wb_sel     = WB_ALU;
      wmask      = '0;
      mem_err    = 1'b0;
      trap_set   = 1'b0;
      if (!rst) begin
         case (state)
            ST_FETCH: begin
               if (inst_valid) begin
                  ir_we      = 1'b1;
                  next_state = ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (dec_class == CLS_ILLEGAL) begin
`ifdef CU_TRAP_EN
                  trap_set   = 1'b1;
                  next_state = ST_TRAP;
`else
                  pc_we      = 1'b1;
                  next_state = ST_FETCH;
`endif
               end else begin
                  next_state = ST_EXEC;
               end
            end
            ST_EXEC: begin
               case (dec_class)
                  CLS_LOAD, CLS_STORE: next_state = ST_MEM;
                  CLS_BRANCH: begin
                     pc_we      = 1'b1;
                     pc_sel     = branch_taken ? PC_BRANCH : PC_PLUS4;
                     next_state = ST_FETCH;
                  end
                  default: next_state = ST_WB;
               endcase
            end
            ST_MEM: begin
`ifdef CU_TRAP_EN
               if (dec_class == CLS_STORE && ir[14:12] == F3_SH && addr_lo[0]) begin
                  trap_set   = 1'b1;
                  next_state = ST_TRAP;
               end else
`endif
               if (tmo_done) begin
                  mem_err    = 1'b1;
                  pc_we      = 1'b1;
                  next_state = ST_FETCH;
               end else begin
                  mem_req = 1'b1;
                  if (dec_class == CLS_STORE) begin
                     mem_we = 1'b1;
                     wmask  = store_mask(ir[14:12], addr_lo);
                  end
                  if (mem_ready) begin
                     if (dec_class == CLS_STORE) begin
                        pc_we      = 1'b1;
                        next_state = ST_FETCH;
                     end else begin
                        next_state = ST_WB;
                     end
                  end
               end
            end
            ST_WB: begin
               reg_write  = (ir[11:7] != 5'd0);
               pc_we      = 1'b1;
               next_state = ST_FETCH;
               case (dec_class)
                  CLS_JAL: begin
                     pc_sel = PC_BRANCH;
                     wb_sel = WB_PC4;
                  end
                  CLS_JALR: begin
                     pc_sel = PC_JALR;
                     wb_sel = WB_PC4;
                  end
                  CLS_LOAD: wb_sel = WB_LOAD;
                  default:  wb_sel = WB_ALU;
               endcase
            end
`ifdef CU_TRAP_EN
            ST_TRAP: next_state = ST_TRAP;
`endif
            default: next_state = ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed self-checking bench for multicycle_cu.
// Honours CU_TRAP_EN when the design is built with it.
module tb_multicycle_cu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst;
   logic        inst_valid, mem_ready, branch_taken;
   logic [1:0]  addr_lo;
   logic [4:0]  rs1, rs2, rd;
   logic        ir_we, pc_we, reg_write, mem_req, mem_we;
   logic [1:0]  pc_sel, wb_sel;
   logic        op_a_sel, op_b_sel;
   logic [3:0]  aluop, wmask;
   logic [2:0]  state_o;
   logic        busy, mem_err, illegal_inst;

   int checks   = 0;
   int failures = 0;

   // Observations gathered by run_instr
   int         obs_len, obs_pcwe_n, obs_memreq_n, obs_wait_n, obs_err_n;
   logic [1:0] obs_pc_sel, obs_wb_sel;
   logic [3:0] obs_aluop, obs_wmask;
   logic       obs_rw, obs_opa, obs_opb, obs_mem_we, obs_irwe;

   always #5 clk = ~clk;

   multicycle_cu #(.MEM_TIMEOUT(16), .ALUOP_W(4)) dut (
      .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
      .mem_ready(mem_ready), .branch_taken(branch_taken), .addr_lo(addr_lo),
      .rs1(rs1), .rs2(rs2), .rd(rd), .ir_we(ir_we), .pc_we(pc_we),
      .reg_write(reg_write), .mem_req(mem_req), .mem_we(mem_we),
      .pc_sel(pc_sel), .wb_sel(wb_sel), .op_a_sel(op_a_sel), .op_b_sel(op_b_sel),
      .aluop(aluop), .wmask(wmask), .state_o(state_o), .busy(busy),
      .mem_err(mem_err), .illegal_inst(illegal_inst)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; inst = '0; inst_valid = 1'b0; mem_ready = 1'b0;
      branch_taken = 1'b0; addr_lo = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Issues one instruction from FETCH and records strobes until FETCH returns.
   // mem_wait < 0 means mem_ready never arrives.
   task automatic run_instr(input logic [31:0] word, input int mem_wait,
                            input logic taken, input logic [1:0] alo);
      int mc;
      mc = 0;
      obs_len = -1; obs_pcwe_n = 0; obs_memreq_n = 0; obs_wait_n = 0; obs_err_n = 0;
      obs_pc_sel = 2'b11; obs_wb_sel = 2'b11; obs_aluop = 4'hx; obs_wmask = 4'h0;
      obs_rw = 1'b0; obs_opa = 1'bx; obs_opb = 1'bx; obs_mem_we = 1'b0;
      branch_taken = taken; addr_lo = alo;
      inst = word; inst_valid = 1'b1;
      @(negedge clk);
      obs_irwe = ir_we;
      next_cycle();
      inst_valid = 1'b0;
      for (int k = 2; k <= 60; k++) begin
         if (state_o == 3'd0) begin
            obs_len = k - 1;
            break;
         end
         mem_ready = 1'b0;
         if (state_o == 3'd3) begin
            mem_ready = (mem_wait >= 0) && (mc == mem_wait);
            mc++;
         end
         @(negedge clk);
         if (pc_we) begin obs_pcwe_n++; obs_pc_sel = pc_sel; end
         if (reg_write) obs_rw = 1'b1;
         if (state_o == 3'd4) obs_wb_sel = wb_sel;
         if (state_o == 3'd2) begin obs_aluop = aluop; obs_opa = op_a_sel; obs_opb = op_b_sel; end
         if (mem_req) begin
            obs_memreq_n++;
            obs_wmask = wmask;
            if (mem_we) obs_mem_we = 1'b1;
            if (!mem_ready) obs_wait_n++;
         end
         if (mem_err) obs_err_n++;
         next_cycle();
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; inst = 32'h002081B3; inst_valid = 1'b1; mem_ready = 1'b1;
      @(negedge clk);
      checks++; if (ir_we !== 1'b0) begin failures++; $display("FAIL reset_irwe_during_rst: got %b expected 0", ir_we); end
      next_cycle();
      next_cycle();
      rst = 1'b0; inst_valid = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state_o); end
      checks++;
      if ({ir_we, pc_we, reg_write, mem_req, mem_we, pc_sel, wb_sel, op_a_sel, op_b_sel,
           aluop, wmask, rs1, rs2, rd, busy, mem_err, illegal_inst} !== 37'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {ir_we, pc_we, reg_write, mem_req, mem_we, pc_sel, wb_sel, op_a_sel, op_b_sel,
                   aluop, wmask, rs1, rs2, rd, busy, mem_err, illegal_inst});
      end
      next_cycle();
   endtask

   task automatic test_add();
      inst = 32'h002081B3; inst_valid = 1'b1;
      @(negedge clk);
      checks++; if (ir_we !== 1'b1) begin failures++; $display("FAIL add_c1_irwe: got %b expected 1", ir_we); end
      next_cycle();
      @(negedge clk);
      checks++; if ({state_o, rs1, rs2, rd} !== {3'd1, 5'd1, 5'd2, 5'd3}) begin failures++; $display("FAIL add_c2_decode: got st=%0d rs1=%0d rs2=%0d rd=%0d expected 1/1/2/3", state_o, rs1, rs2, rd); end
      checks++; if (ir_we !== 1'b0) begin failures++; $display("FAIL add_c2_irwe_ignored: got %b expected 0", ir_we); end
      next_cycle();
      @(negedge clk);
      checks++; if ({state_o, aluop, op_a_sel, op_b_sel} !== {3'd2, 4'b0000, 1'b0, 1'b0}) begin failures++; $display("FAIL add_c3_exec: got st=%0d aluop=%b a=%b b=%b expected 2/0000/0/0", state_o, aluop, op_a_sel, op_b_sel); end
      next_cycle();
      @(negedge clk);
      checks++; if ({state_o, reg_write, wb_sel, pc_we, pc_sel} !== {3'd4, 1'b1, 2'b00, 1'b1, 2'b00}) begin failures++; $display("FAIL add_c4_wb: got st=%0d rw=%b wb=%b pcwe=%b pcsel=%b expected 4/1/00/1/00", state_o, reg_write, wb_sel, pc_we, pc_sel); end
      next_cycle();
      inst_valid = 1'b0;
      @(negedge clk);
      checks++; if ({state_o, busy} !== {3'd0, 1'b0}) begin failures++; $display("FAIL add_c5_fetch: got st=%0d busy=%b expected 0/0", state_o, busy); end
      next_cycle();
   endtask

   task automatic test_alu_variants();
      // SUB: R-type with f7[5]
      run_instr(32'h402081B3, 0, 1'b0, 2'b00);
      checks++; if ({obs_aluop, obs_opb} !== {4'b1000, 1'b0}) begin failures++; $display("FAIL sub_aluop: got %b/%b expected 1000/0", obs_aluop, obs_opb); end
      // SRAI x4,x1,3
      run_instr(32'h4030D213, 0, 1'b0, 2'b00);
      checks++; if ({obs_aluop, obs_opb, obs_len} !== {4'b1101, 1'b1, 32'd4}) begin failures++; $display("FAIL srai: got aluop=%b b=%b len=%0d expected 1101/1/4", obs_aluop, obs_opb, obs_len); end
      // ADDI with imm bit 30 set: f7 bit ignored for f3=000
      run_instr(32'h40008213, 0, 1'b0, 2'b00);
      checks++; if (obs_aluop !== 4'b0000) begin failures++; $display("FAIL addi_aluop: got %b expected 0000", obs_aluop); end
      // LUI x5
      run_instr(32'h123452B7, 0, 1'b0, 2'b00);
      checks++; if ({obs_aluop, obs_opa, obs_opb, obs_wb_sel} !== {4'b1111, 1'b0, 1'b1, 2'b00}) begin failures++; $display("FAIL lui: got aluop=%b a=%b b=%b wb=%b expected 1111/0/1/00", obs_aluop, obs_opa, obs_opb, obs_wb_sel); end
      // AUIPC x5
      run_instr(32'h00000297, 0, 1'b0, 2'b00);
      checks++; if ({obs_aluop, obs_opa, obs_opb} !== {4'b0000, 1'b1, 1'b1}) begin failures++; $display("FAIL auipc: got aluop=%b a=%b b=%b expected 0000/1/1", obs_aluop, obs_opa, obs_opb); end
   endtask

   task automatic test_load();
      run_instr(32'h0000A283, 3, 1'b0, 2'b00);
      checks++; if (obs_len !== 8) begin failures++; $display("FAIL load_len: got %0d expected 8", obs_len); end
      checks++; if (obs_wait_n !== 3) begin failures++; $display("FAIL load_wait_cycles: got %0d expected 3", obs_wait_n); end
      checks++; if ({obs_wb_sel, obs_rw, obs_mem_we} !== {2'b01, 1'b1, 1'b0}) begin failures++; $display("FAIL load_wb: got wb=%b rw=%b we=%b expected 01/1/0", obs_wb_sel, obs_rw, obs_mem_we); end
      // zero-wait load
      run_instr(32'h0000A283, 0, 1'b0, 2'b00);
      checks++; if (obs_len !== 5) begin failures++; $display("FAIL load0_len: got %0d expected 5", obs_len); end
   endtask

   task automatic test_store();
      run_instr(32'h00208023, 0, 1'b0, 2'b10);
      checks++; if ({obs_wmask, obs_mem_we, obs_rw} !== {4'b0100, 1'b1, 1'b0}) begin failures++; $display("FAIL sb_mask: got mask=%b we=%b rw=%b expected 0100/1/0", obs_wmask, obs_mem_we, obs_rw); end
      checks++; if ({obs_len, obs_pcwe_n, obs_pc_sel} !== {32'd4, 32'd1, 2'b00}) begin failures++; $display("FAIL sb_len: got len=%0d pcwe=%0d sel=%b expected 4/1/00", obs_len, obs_pcwe_n, obs_pc_sel); end
      run_instr(32'h00209023, 0, 1'b0, 2'b10);
      checks++; if (obs_wmask !== 4'b1100) begin failures++; $display("FAIL sh_mask: got %b expected 1100", obs_wmask); end
      run_instr(32'h0020A023, 0, 1'b0, 2'b01);
      checks++; if (obs_wmask !== 4'b1111) begin failures++; $display("FAIL sw_mask: got %b expected 1111", obs_wmask); end
      run_instr(32'h00209023, 0, 1'b0, 2'b11);
`ifdef CU_TRAP_EN
      checks++; if ({state_o, illegal_inst, obs_memreq_n} !== {3'd5, 1'b1, 32'd0}) begin failures++; $display("FAIL sh_misaligned_trap: got st=%0d ill=%b req=%0d expected 5/1/0", state_o, illegal_inst, obs_memreq_n); end
      do_reset();
`else
      checks++; if ({obs_wmask, obs_len} !== {4'b1100, 32'd4}) begin failures++; $display("FAIL sh_misaligned: got mask=%b len=%0d expected 1100/4", obs_wmask, obs_len); end
`endif
   endtask

   task automatic test_branch();
      run_instr(32'h00208463, 0, 1'b1, 2'b00);
      checks++; if ({obs_len, obs_pcwe_n, obs_pc_sel, obs_rw} !== {32'd3, 32'd1, 2'b01, 1'b0}) begin failures++; $display("FAIL beq_taken: got len=%0d pcwe=%0d sel=%b rw=%b expected 3/1/01/0", obs_len, obs_pcwe_n, obs_pc_sel, obs_rw); end
      checks++; if ({obs_aluop, obs_opb} !== {4'b1000, 1'b0}) begin failures++; $display("FAIL beq_aluop: got %b/%b expected 1000/0", obs_aluop, obs_opb); end
      run_instr(32'h00208463, 0, 1'b0, 2'b00);
      checks++; if ({obs_len, obs_pc_sel} !== {32'd3, 2'b00}) begin failures++; $display("FAIL beq_not_taken: got len=%0d sel=%b expected 3/00", obs_len, obs_pc_sel); end
   endtask

   task automatic test_timeout();
      run_instr(32'h0020A023, -1, 1'b0, 2'b00);
      checks++; if (obs_memreq_n !== 16) begin failures++; $display("FAIL tmo_req_cycles: got %0d expected 16", obs_memreq_n); end
      checks++; if ({obs_err_n, obs_len, obs_pc_sel} !== {32'd1, 32'd20, 2'b00}) begin failures++; $display("FAIL tmo_abort: got err=%0d len=%0d sel=%b expected 1/20/00", obs_err_n, obs_len, obs_pc_sel); end
      @(negedge clk);
      checks++; if ({state_o, mem_req, mem_err} !== {3'd0, 1'b0, 1'b0}) begin failures++; $display("FAIL tmo_after: got st=%0d req=%b err=%b expected 0/0/0", state_o, mem_req, mem_err); end
      next_cycle();
   endtask

   task automatic test_illegal();
      run_instr(32'h0000007F, 0, 1'b0, 2'b00);
`ifdef CU_TRAP_EN
      checks++; if ({state_o, illegal_inst, obs_pcwe_n} !== {3'd5, 1'b1, 32'd0}) begin failures++; $display("FAIL illegal_trap: got st=%0d ill=%b pcwe=%0d expected 5/1/0", state_o, illegal_inst, obs_pcwe_n); end
      do_reset();
      @(negedge clk);
      checks++; if (illegal_inst !== 1'b0) begin failures++; $display("FAIL illegal_cleared: got %b expected 0", illegal_inst); end
      next_cycle();
`else
      checks++; if ({obs_len, obs_pcwe_n, obs_pc_sel, obs_rw} !== {32'd2, 32'd1, 2'b00, 1'b0}) begin failures++; $display("FAIL illegal_skip: got len=%0d pcwe=%0d sel=%b rw=%b expected 2/1/00/0", obs_len, obs_pcwe_n, obs_pc_sel, obs_rw); end
      checks++; if (illegal_inst !== 1'b0) begin failures++; $display("FAIL illegal_flag: got %b expected 0", illegal_inst); end
`endif
   endtask

   task automatic test_back_to_back();
      // JAL x1,+16
      run_instr(32'h010000EF, 0, 1'b0, 2'b00);
      checks++; if ({obs_len, obs_pc_sel, obs_wb_sel, obs_rw, obs_opa} !== {32'd4, 2'b01, 2'b10, 1'b1, 1'b1}) begin failures++; $display("FAIL jal: got len=%0d sel=%b wb=%b rw=%b a=%b expected 4/01/10/1/1", obs_len, obs_pc_sel, obs_wb_sel, obs_rw, obs_opa); end
      // JALR x0,0(x1): rd=0 suppresses the write
      run_instr(32'h00008067, 0, 1'b0, 2'b00);
      checks++; if ({obs_len, obs_pc_sel, obs_wb_sel, obs_rw, obs_opa} !== {32'd4, 2'b10, 2'b10, 1'b0, 1'b0}) begin failures++; $display("FAIL jalr: got len=%0d sel=%b wb=%b rw=%b a=%b expected 4/10/10/0/0", obs_len, obs_pc_sel, obs_wb_sel, obs_rw, obs_opa); end
      checks++; if (obs_irwe !== 1'b1) begin failures++; $display("FAIL b2b_irwe: got %b expected 1", obs_irwe); end
   endtask

   task automatic test_reset_mid_mem();
      inst = 32'h0000A283; inst_valid = 1'b1; mem_ready = 1'b0;
      next_cycle();
      inst_valid = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      checks++; if ({state_o, mem_req} !== {3'd3, 1'b1}) begin failures++; $display("FAIL rstmem_in_mem: got st=%0d req=%b expected 3/1", state_o, mem_req); end
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      checks++; if ({state_o, mem_req, pc_we, reg_write} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin failures++; $display("FAIL rstmem_after: got st=%0d req=%b pcwe=%b rw=%b expected 0/0/0/0", state_o, mem_req, pc_we, reg_write); end
      next_cycle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      test_reset();
      test_add();
      test_alu_variants();
      test_load();
      test_store();
      test_branch();
      test_timeout();
      test_illegal();
      test_back_to_back();
      test_reset_mid_mem();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
